// File: rtl/shift_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : shift_deserializer
// Description : Serial-to-parallel receive shifter. Collects one qualified
//               bit per clock, assembles WIDTH-bit words (MSB- or LSB-first,
//               chosen per frame) and presents each completed word on a
//               valid/ready output register with a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             lsb_first,
  input  logic             d_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             overrun
);

  // Counter only needs to reach WIDTH-1; completion wraps it back to 0.
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             lsb_q,     lsb_d;
  logic [WIDTH-1:0] dout_q,    dout_d;
  logic             dvalid_q,  dvalid_d;
  logic             busy_q,    busy_d;
  logic             overrun_q, overrun_d;

  // Working values for the current cycle: a frame_start overrides the
  // stored frame context so a bit arriving on the same cycle belongs to
  // the new frame.
  logic             frame_active;
  logic             base_lsb;
  logic [CNT_W-1:0] base_cnt;
  logic [WIDTH-1:0] base_sh;
  logic [WIDTH-1:0] shifted;
  logic             word_done;
  logic             overrun_set;

  // Next-state logic for the shifter, counter and output register.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    lsb_d       = lsb_q;
    dout_d      = dout_q;
    dvalid_d    = dvalid_q;
    overrun_d   = overrun_q;
    word_done   = 1'b0;
    overrun_set = 1'b0;

    frame_active = (state_q == ST_SHIFT) || frame_start;
    base_lsb     = frame_start ? lsb_first   : lsb_q;
    base_cnt     = frame_start ? '0          : cnt_q;
    base_sh      = frame_start ? '0          : shreg_q;

    // Direction decides which end the new bit enters from.
    if (base_lsb) begin
      shifted = {bit_in, base_sh[WIDTH-1:1]};
    end else begin
      shifted = {base_sh[WIDTH-2:0], bit_in};
    end

    // A restart silently drops the partial word and relatches direction.
    if (frame_start) begin
      state_d = ST_SHIFT;
      lsb_d   = lsb_first;
      cnt_d   = '0;
      shreg_d = '0;
    end

    // Accept a bit only inside a frame; IDLE ignores bit_valid.
    if (frame_active && bit_valid) begin
      shreg_d = shifted;
      if (base_cnt == C_CNT_LAST) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = base_cnt + C_CNT_ONE;
      end
    end

    // Consumer handshake retires the held word.
    if (dvalid_q && d_ready) begin
      dvalid_d = 1'b0;
    end

    // A completed word loads when the output slot is free or being freed
    // on this same edge; otherwise it is lost and flagged.
    if (word_done) begin
      if (!dvalid_q || d_ready) begin
        dout_d   = shifted;
        dvalid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end

    // Set has priority over clear so a drop is never hidden.
    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d == ST_SHIFT) && (cnt_d != '0);
  end

  // State register with synchronous reset; all outputs come from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      lsb_q     <= 1'b0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      lsb_q     <= lsb_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign d_out   = dout_q;
  assign d_valid = dvalid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_deserializer
// Description : Self-checking bench for shift_deserializer: a vector table,
//               directed multi-cycle sequences and random stimulus, all
//               compared against a queue-based word-assembly model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, frame_start, bit_in, bit_valid, lsb_first, d_ready, clr_overrun;
  logic [W-1:0] d_out;
  logic         d_valid, busy, overrun;

  int checks   = 0;
  int failures = 0;

  shift_deserializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .lsb_first   (lsb_first),
    .d_ready     (d_ready),
    .clr_overrun (clr_overrun),
    .d_out       (d_out),
    .d_valid     (d_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: frame context plus a queue of bits received so far.
  bit           m_active;
  bit           m_lsb;
  bit           m_bits[$];
  logic [W-1:0] m_dout;
  bit           m_dv;
  bit           m_ovr;

  function automatic logic [W-1:0] assemble(input bit lsb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb) w[i] = m_bits[i];
      else     w[W-1-i] = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_update(input logic r, fs, bv, b, l, rdy, clr);
    logic [W-1:0] word;
    bit got, consumed;
    if (r) begin
      m_active = 0; m_lsb = 0; m_bits.delete();
      m_dout = '0; m_dv = 0; m_ovr = 0;
      return;
    end
    got      = 0;
    word     = '0;
    consumed = m_dv && rdy;
    if (fs) begin
      m_active = 1; m_lsb = l; m_bits.delete();
    end
    if (m_active && bv) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        word = assemble(m_lsb);
        m_bits.delete();
        got = 1;
      end
    end
    if (consumed) m_dv = 0;
    if (clr) m_ovr = 0;
    if (got) begin
      if (!m_dv) begin
        m_dout = word; m_dv = 1;
      end else begin
        m_ovr = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("d_out",   16'(d_out),   16'(m_dout));
    check("d_valid", 16'(d_valid), 16'(m_dv));
    check("busy",    16'(busy),    16'(m_active && m_bits.size() != 0));
    check("overrun", 16'(overrun), 16'(m_ovr));
  endtask

  // Apply one cycle of inputs, then compare all outputs with the model.
  task automatic step(input logic r, fs, bv, b, l, rdy, clr);
    rst = r; frame_start = fs; bit_valid = bv; bit_in = b;
    lsb_first = l; d_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    #1;
    model_update(r, fs, bv, b, l, rdy, clr);
    compare_model();
  endtask

  // Send a word's bits in arrival order, first arriving bit = w[W-1].
  task automatic send_word(input logic [W-1:0] w, input logic l, input logic rdy);
    for (int i = W - 1; i >= 0; i--) step(0, 0, 1, w[i], l, rdy, 0);
  endtask

  typedef struct packed {
    logic         fs, bv, b, l, rdy;
    logic [W-1:0] e_dout;
    logic         e_dv, e_busy, e_ovr;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [W-1:0] pat;

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_d_out",   16'(d_out),   16'h0);
    check("rst_d_valid", 16'(d_valid), 16'h0);
    check("rst_busy",    16'(busy),    16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);

    // MSB-first A5, then LSB-first A5 with frame_start+bit on one cycle.
    //          fs   bv   b    l    rdy   dout   dv   busy ovr
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 8'h00, 1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 8'h00, 1'b0,1'b1,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 8'h00, 1'b0,1'b1,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 8'h00, 1'b0,1'b1,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 8'h00, 1'b0,1'b1,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 8'h00, 1'b0,1'b1,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 8'h00, 1'b0,1'b1,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 8'h00, 1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 8'hA5, 1'b1,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 8'hA5, 1'b0,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 8'hA5, 1'b0,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 8'hA5, 1'b0,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 8'hA5, 1'b0,1'b1,1'b0};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 8'hA5, 1'b0,1'b1,1'b0};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 8'hA5, 1'b0,1'b1,1'b0};
    tbl[15] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 8'hA5, 1'b0,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 8'hA5, 1'b0,1'b1,1'b0};
    tbl[17] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 8'hA5, 1'b1,1'b0,1'b0};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 8'hA5, 1'b0,1'b0,1'b0};
    tbl[19] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 8'hA5, 1'b0,1'b1,1'b0};
    for (int i = 0; i < 20; i++) begin
      step(0, tbl[i].fs, tbl[i].bv, tbl[i].b, tbl[i].l, tbl[i].rdy, 0);
      check($sformatf("tbl%0d_d_out", i),   16'(d_out),   16'(tbl[i].e_dout));
      check($sformatf("tbl%0d_d_valid", i), 16'(d_valid), 16'(tbl[i].e_dv));
      check($sformatf("tbl%0d_busy", i),    16'(busy),    16'(tbl[i].e_busy));
      check($sformatf("tbl%0d_overrun", i), 16'(overrun), 16'(tbl[i].e_ovr));
    end

    // Stall/overrun: 3C held while C3 is dropped.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    send_word(8'h3C, 0, 0);
    check("stall_first_word", 16'(d_out), 16'h3C);
    check("stall_first_valid", 16'(d_valid), 16'h1);
    send_word(8'hC3, 0, 0);
    check("stall_held_word", 16'(d_out), 16'h3C);
    check("stall_overrun_set", 16'(overrun), 16'h1);
    step(0, 0, 0, 0, 0, 1, 0);
    check("stall_valid_fall", 16'(d_valid), 16'h0);
    check("stall_c3_never", 16'(d_out), 16'h3C);
    step(0, 0, 0, 0, 0, 1, 1);
    check("clr_overrun", 16'(overrun), 16'h0);

    // Gaps then restart with frame_start and bit_valid together.
    step(0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step(0, 0, 0, 1'($urandom), 0, 1, 0);
      step(0, 0, 1, 1'($urandom), 0, 1, 0);
    end
    step(0, 1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0, 1, 0);
    check("restart_word", 16'(d_out), 16'hFF);
    check("restart_valid", 16'(d_valid), 16'h1);
    check("restart_no_ovr", 16'(overrun), 16'h0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("restart_single", 16'(d_valid), 16'h0);

    // Simultaneous handshake with a new word completing.
    step(0, 1, 0, 0, 0, 0, 0);
    send_word(8'h12, 0, 0);
    pat = 8'h34;
    for (int i = W - 1; i >= 1; i--) step(0, 0, 1, pat[i], 0, 0, 0);
    step(0, 0, 1, pat[0], 0, 1, 0);
    check("simul_word", 16'(d_out), 16'h34);
    check("simul_valid", 16'(d_valid), 16'h1);
    check("simul_no_ovr", 16'(overrun), 16'h0);

    // Reset mid-frame while a word is pending.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("midrst_d_out", 16'(d_out), 16'h0);
    check("midrst_valid", 16'(d_valid), 16'h0);
    check("midrst_busy", 16'(busy), 16'h0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0, 1, 0);
    check("midrst_ignore_busy", 16'(busy), 16'h0);
    check("midrst_ignore_valid", 16'(d_valid), 16'h0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           1'($urandom),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receive shifter: collects a bit-serial stream, one qualified bit per clock, and assembles it into WIDTH-bit words. It is the receiving end for words that the 8-bit shifter serialises out one bit at a time. Each completed word is presented on a valid/ready output register. A sticky overrun flag reports words dropped while the consumer stalls.

## Interface
- WIDTH, 8: word width in bits; legal range 2..16.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- frame_start  input  1  pulse; aborts any partial word and starts a new one.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is sampled on this cycle.
- lsb_first  input  1  0: first bit received is bit WIDTH-1; 1: first bit received is bit 0. Sampled only on frame_start.
- d_ready  input  1  consumer accepts d_out.
- d_out  output  WIDTH  assembled word, held while d_valid=1.
- d_valid  output  1  d_out holds an unconsumed word.
- busy  output  1  a partial word is in progress.
- overrun  output  1  sticky; set when a completed word is dropped.
- clr_overrun  input  1  clears overrun.

## Operation
- Reset (rst=1 at a clock edge) forces:
  - state IDLE; shift register, bit counter and lsb_first latch all 0.
  - d_out=0, d_valid=0, busy=0, overrun=0.
- States:
  - IDLE: ignores bit_valid. frame_start goes to SHIFT, latches lsb_first, clears the counter.
  - SHIFT: on each bit_valid=1, shifts bit_in in and increments the counter.
    - MSB-first: shift left, new bit enters at bit 0.
    - LSB-first: shift right, new bit enters at bit WIDTH-1.
  - When the WIDTH-th bit is accepted, the word completes and the state returns to SHIFT with the counter at 0. Streaming continues with no new frame_start.
- Frame_start in SHIFT restarts the frame: the partial word is discarded silently (no overrun) and lsb_first is relatched.
- Frame_start together with bit_valid on the same cycle: the new frame starts and that bit is its first bit.
- Word completion:
  - If d_valid=0, or d_valid=1 and d_ready=1 on the same cycle: d_out loads the completed word and d_valid=1.
  - If d_valid=1 and d_ready=0: the new word is dropped, d_out is unchanged, and overrun is set.
- Output handshake: d_valid falls on the cycle after d_valid and d_ready are both 1, unless a new word loads on that same edge.
- busy=1 in SHIFT while the counter is nonzero.
- Overrun:
  - Cleared by clr_overrun.
  - A set event on the same cycle as clr_overrun wins, so overrun stays 1.
- Bit counter width is clog2(WIDTH); it never exceeds WIDTH-1.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- Latency: d_valid rises on the edge that samples the WIDTH-th bit, so it is visible one cycle after that bit is presented.
- Throughput: one word per WIDTH valid bits.
  - A consumer holding d_ready=1 never causes overrun.
  - Back-to-back words have no gap cycle.
- bit_valid gaps of any length are allowed; the counter holds across them.
- rst mid-frame discards the partial word and any pending d_out. The next edge without rst is in IDLE, and bits are ignored until frame_start.

## Test plan
- MSB-first basic: rst, then frame_start with lsb_first=0, then bits 1,0,1,0,0,1,0,1 on consecutive cycles with d_ready=1. Expect d_out=8'hA5 and d_valid=1 for exactly one cycle, one cycle after the 8th bit; busy=0 afterwards.
- LSB-first: same bit sequence with lsb_first=1. Expect d_out=8'hA5 (bits reversed relative to arrival).
- Stall/overrun:
  - Stream 8'h3C then 8'hC3 with d_ready=0. Expect d_out to stay 8'h3C with d_valid=1, and overrun to be set on the 16th bit.
  - Raise d_ready: d_valid falls on the next cycle and 8'hC3 is never presented.
  - Pulse clr_overrun: overrun=0.
- Gaps and restart:
  - Send 5 bits with random bit_valid gaps, then frame_start with bit_valid=1 on the same cycle.
  - Follow with 7 more bits forming 8'hFF. Expect a single word 8'hFF and no overrun.
- Simultaneous handshake: d_valid=1 with d_ready=1 on the same cycle as a new word completes. Expect d_out to update to the new word, d_valid to stay 1, and overrun=0.
- Reset mid-operation: assert rst after 4 bits while d_valid=1. Expect all outputs 0 on the next cycle, and bits without frame_start to leave busy=0.
